// File: rtl/cla4_aug_reg.sv
// 4-bit two-level carry-lookahead adder with group P/G outputs.
// Results are registered, one cycle after in_valid.
module cla4_aug_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carryInput,
  output logic       out_valid,
  output logic [3:0] sum,
  output logic       carryOutput,
  output logic       prop,
  output logic       gene
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;
  logic [3:0] sum_d;
  logic       co_d;
  logic       prop_d;
  logic       gene_d;

  logic [3:0] sum_q;
  logic       co_q;
  logic       prop_q;
  logic       gene_q;
  logic       vld_q;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat sum-of-products; no term depends on another carry.
  always_comb begin
    c[0] = carryInput;
    c[1] = g[0]
         | (p[0] & carryInput);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & carryInput);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carryInput);
    sum_d  = p ^ c;
    prop_d = &p;
    gene_d = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
    co_d   = gene_d | (prop_d & carryInput);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= 4'b0000;
      co_q   <= 1'b0;
      prop_q <= 1'b0;
      gene_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        co_q   <= co_d;
        prop_q <= prop_d;
        gene_q <= gene_d;
      end
    end
  end

  assign out_valid   = vld_q;
  assign sum         = sum_q;
  assign carryOutput = co_q;
  assign prop        = prop_q;
  assign gene        = gene_q;

endmodule

// File: tb/tb_cla4_aug_reg.sv
// Randomized self-checking bench for cla4_aug_reg against
// an arithmetic reference model.
module tb_cla4_aug_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       carryInput = 1'b0;
  logic       out_valid;
  logic [3:0] sum;
  logic       carryOutput;
  logic       prop;
  logic       gene;

  int n_cmp = 0;
  int n_err = 0;

  cla4_aug_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .carryInput  (carryInput),
    .out_valid   (out_valid),
    .sum         (sum),
    .carryOutput (carryOutput),
    .prop        (prop),
    .gene        (gene)
  );

  always #5 clk = ~clk;

  // Reference: {carry, sum[3:0], P, G} from plain integer arithmetic.
  function automatic logic [6:0] ref_model(
    input int ia, input int ib, input int ic
  );
    int t;
    logic pp;
    logic gg;
    t  = ia + ib + ic;
    pp = ((ia + ib) == 15);
    gg = ((ia + ib) >= 16);
    return {t[4], t[3:0], pp, gg};
  endfunction

  // Present one input set and advance past the capturing edge.
  task automatic drive(
    input logic v, input logic [3:0] ia,
    input logic [3:0] ib, input logic ic
  );
    in_valid   = v;
    a          = ia;
    b          = ib;
    carryInput = ic;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst_n = 1'b0;
    #2;
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (got !== 7'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init got=%b vld=%b want=0", got, out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    in_valid = 1'b1;
    a = 4'h3;
    #2;
    rst_n = 1'b0;
    #1;
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (got !== 7'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async got=%b vld=%b want=0", got, out_valid);
    end
    @(posedge clk);
    #1;
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (got !== 7'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held got=%b vld=%b want=0", got, out_valid);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle vld=%b want=0", out_valid);
    end
    drive(1'b1, 4'h4, 4'h9, 1'b0);
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (out_valid !== 1'b1 || got !== 7'b0_1101_00) begin
      n_err++;
      $display("FAIL reset_first got=%b vld=%b want=0110100 vld=1",
               got, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [3:0] va [6] = '{4'h4, 4'h9, 4'hC, 4'hF, 4'hF, 4'hA};
    logic [3:0] vb [6] = '{4'h9, 4'hA, 4'h9, 4'hF, 4'hF, 4'h5};
    logic       vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0] ve [6] = '{7'b0_1101_00, 7'b1_0011_01,
                           7'b1_0101_01, 7'b1_1110_01,
                           7'b1_1111_01, 7'b1_0000_10};
    logic [6:0] got;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, va[i], vb[i], vc[i]);
      got = {carryOutput, sum, prop, gene};
      n_cmp++;
      if (out_valid !== 1'b1 || got !== ve[i]) begin
        n_err++;
        $display("FAIL directed_%0d got=%b vld=%b want=%b",
                 i, got, out_valid, ve[i]);
      end
    end
    drive(1'b1, 4'hA, 4'h5, 1'b0);
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (got !== 7'b0_1111_10) begin
      n_err++;
      $display("FAIL prop_chain_c0 got=%b want=0111110", got);
    end
  endtask

  task automatic test_exhaustive;
    logic [6:0] exp;
    logic [6:0] got;
    logic [6:0] last;
    int ia;
    int ib;
    int ic;
    for (int i = 0; i < 512; i++) begin
      ia = i[8:5];
      ib = i[4:1];
      ic = i[0];
      exp = ref_model(ia, ib, ic);
      drive(1'b1, ia[3:0], ib[3:0], ic[0]);
      got = {carryOutput, sum, prop, gene};
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp) begin
        n_err++;
        $display("FAIL exh a=%h b=%h c=%0d got=%b vld=%b want=%b",
                 ia, ib, ic, got, out_valid, exp);
      end
      n_cmp++;
      if (prop === 1'b1 && gene === 1'b1) begin
        n_err++;
        $display("FAIL pg_excl a=%h b=%h got P=1 G=1 want not both",
                 ia, ib);
      end
      last = exp;
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        got = {carryOutput, sum, prop, gene};
        n_cmp++;
        if (out_valid !== 1'b0 || got !== last) begin
          n_err++;
          $display("FAIL gap_hold got=%b vld=%b want=%b vld=0",
                   got, out_valid, last);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp;
    logic [6:0] got;
    int ia;
    int ib;
    int ic;
    for (int i = 0; i < 200; i++) begin
      ia  = $urandom_range(0, 15);
      ib  = $urandom_range(0, 15);
      ic  = $urandom_range(0, 1);
      exp = ref_model(ia, ib, ic);
      drive(1'b1, ia[3:0], ib[3:0], ic[0]);
      got = {carryOutput, sum, prop, gene};
      n_cmp++;
      if (out_valid !== 1'b1 || got !== exp) begin
        n_err++;
        $display("FAIL b2b a=%h b=%h c=%0d got=%b vld=%b want=%b",
                 ia, ib, ic, got, out_valid, exp);
      end
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    got = {carryOutput, sum, prop, gene};
    n_cmp++;
    if (out_valid !== 1'b0 || got !== exp) begin
      n_err++;
      $display("FAIL b2b_tail got=%b vld=%b want=%b vld=0",
               got, out_valid, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
